// File: rtl/receptor_serial_paridade.sv
// Serial receiver for 8-bit-period frames (start, D0..D4 LSB first, parity, stop).
// Deserialises the frame into E[4:0] and P and holds them for the Display stage.
// Parity is forwarded verbatim; Display is responsible for validating it.
module receptor_serial_paridade #(
  parameter int unsigned CICLOS_POR_BIT = 4,
  parameter int unsigned LARGURA_CONT   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [4:0] E,
  output logic       P,
  output logic       pronto,
  output logic       erro_quadro,
  output logic       ocupado
);

  localparam logic [LARGURA_CONT-1:0] LP_FIM_BIT  = LARGURA_CONT'(CICLOS_POR_BIT - 1);
  localparam logic [LARGURA_CONT-1:0] LP_MEIO_BIT = LARGURA_CONT'(CICLOS_POR_BIT / 2 - 1);
  localparam logic [2:0]              LP_ULT_DADO = 3'd4;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4,
    ESPERA   = 3'd5
  } t_estado;

  t_estado                 r_estado;
  logic                    r_rx_meta;
  logic                    r_rx_s;
  logic [LARGURA_CONT-1:0] r_cnt;
  logic [2:0]              r_indice;
  logic [4:0]              r_shift;
  logic                    r_par;
  logic [4:0]              r_E;
  logic                    r_P;
  logic                    r_pronto;
  logic                    r_erro_quadro;
  logic                    r_ocupado;

  logic w_fim_bit;
  logic w_meio_bit;

  assign w_fim_bit  = (r_cnt == LP_FIM_BIT);
  assign w_meio_bit = (r_cnt == LP_MEIO_BIT);

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame FSM with bit timing, deserialisation and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado      <= OCIOSO;
      r_cnt         <= '0;
      r_indice      <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_E           <= 5'b00000;
      r_P           <= 1'b1;
      r_pronto      <= 1'b0;
      r_erro_quadro <= 1'b0;
      r_ocupado     <= 1'b0;
    end else begin
      r_pronto      <= 1'b0;
      r_erro_quadro <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (!r_rx_s) begin
            r_estado  <= INICIO;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
          end
        end
        INICIO: begin
          if (w_meio_bit) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_estado <= DADOS;
              r_indice <= '0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              r_estado  <= OCIOSO;
              r_ocupado <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + LARGURA_CONT'(1);
          end
        end
        DADOS: begin
          if (w_fim_bit) begin
            r_cnt             <= '0;
            r_shift[r_indice] <= r_rx_s;
            r_indice          <= r_indice + 3'd1;
            if (r_indice == LP_ULT_DADO) begin
              r_estado <= PARIDADE;
            end
          end else begin
            r_cnt <= r_cnt + LARGURA_CONT'(1);
          end
        end
        PARIDADE: begin
          if (w_fim_bit) begin
            r_cnt    <= '0;
            r_par    <= r_rx_s;
            r_estado <= PARADA;
          end else begin
            r_cnt <= r_cnt + LARGURA_CONT'(1);
          end
        end
        PARADA: begin
          if (w_fim_bit) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_E       <= r_shift;
              r_P       <= r_par;
              r_pronto  <= 1'b1;
              r_estado  <= OCIOSO;
              r_ocupado <= 1'b0;
            end else begin
              r_erro_quadro <= 1'b1;
              r_estado      <= ESPERA;
            end
          end else begin
            r_cnt <= r_cnt + LARGURA_CONT'(1);
          end
        end
        ESPERA: begin
          // Held-low line must return high before a new start bit is honoured.
          if (r_rx_s) begin
            r_estado  <= OCIOSO;
            r_ocupado <= 1'b0;
          end
        end
        default: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign E           = r_E;
  assign P           = r_P;
  assign pronto      = r_pronto;
  assign erro_quadro = r_erro_quadro;
  assign ocupado     = r_ocupado;

endmodule

// File: tb/tb_receptor_serial_paridade.sv
// Directed bench for receptor_serial_paridade with N=4 cycles per bit.
module tb_receptor_serial_paridade;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [4:0] E;
  logic       P;
  logic       pronto;
  logic       erro_quadro;
  logic       ocupado;

  always #5 clk = ~clk;

  receptor_serial_paridade #(
    .CICLOS_POR_BIT(N),
    .LARGURA_CONT  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .E          (E),
    .P          (P),
    .pronto     (pronto),
    .erro_quadro(erro_quadro),
    .ocupado    (ocupado)
  );

  // Edge counter: after edge k has settled, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor sampled on the falling edge.
  int         pronto_cnt      = 0;
  int         erro_cnt        = 0;
  int         last_pronto_cyc = -1;
  int         last_erro_cyc   = -1;
  logic [4:0] pronto_E [0:15];
  int         pronto_cyc [0:15];
  int         overlap_err     = 0;
  int         consec_err      = 0;
  int         ep_err          = 0;
  logic       prev_pronto     = 1'b0;
  logic       prev_erro       = 1'b0;
  logic [4:0] prev_E          = 5'b00000;
  logic       prev_P          = 1'b1;

  always @(negedge clk) begin
    if (pronto === 1'b1) begin
      if (pronto_cnt < 16) begin
        pronto_E[pronto_cnt]   <= E;
        pronto_cyc[pronto_cnt] <= cyc;
      end
      pronto_cnt      <= pronto_cnt + 1;
      last_pronto_cyc <= cyc;
    end
    if (erro_quadro === 1'b1) begin
      erro_cnt      <= erro_cnt + 1;
      last_erro_cyc <= cyc;
    end
    if (pronto === 1'b1 && erro_quadro === 1'b1) overlap_err <= overlap_err + 1;
    if ((pronto === 1'b1 && prev_pronto) || (erro_quadro === 1'b1 && prev_erro))
      consec_err <= consec_err + 1;
    if (rst_n === 1'b1 && pronto !== 1'b1 && (E !== prev_E || P !== prev_P))
      ep_err <= ep_err + 1;
    prev_pronto <= (pronto === 1'b1);
    prev_erro   <= (erro_quadro === 1'b1);
    prev_E      <= E;
    prev_P      <= P;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one full frame; must be called at posedge+#1. k is the first edge seeing the start bit.
  task automatic send_frame(input logic [4:0] d, input logic p, input logic s, output int k);
    logic [7:0] b;
    b = {s, p, d, 1'b0};
    k = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(N);
    end
  endtask

  typedef struct {
    logic [4:0] d;
    logic       p;
    logic       s;
    int         low_extra;
    logic       exp_pronto;
    logic [4:0] exp_E;
    logic       exp_P;
    logic       exp_valid;
  } vec_t;

  vec_t vt [0:4];

  initial begin
    int k, k1, k2, p0, e0, hi_cnt;

    vt[0] = '{d: 5'b00001, p: 1'b0, s: 1'b1, low_extra: 0,  exp_pronto: 1'b1, exp_E: 5'b00001, exp_P: 1'b0, exp_valid: 1'b1};
    vt[1] = '{d: 5'b00001, p: 1'b1, s: 1'b1, low_extra: 0,  exp_pronto: 1'b1, exp_E: 5'b00001, exp_P: 1'b1, exp_valid: 1'b0};
    vt[2] = '{d: 5'b10101, p: 1'b0, s: 1'b0, low_extra: 10, exp_pronto: 1'b0, exp_E: 5'b00001, exp_P: 1'b1, exp_valid: 1'b0};
    vt[3] = '{d: 5'b11111, p: 1'b0, s: 1'b1, low_extra: 0,  exp_pronto: 1'b1, exp_E: 5'b11111, exp_P: 1'b0, exp_valid: 1'b1};
    vt[4] = '{d: 5'b01100, p: 1'b1, s: 1'b1, low_extra: 0,  exp_pronto: 1'b1, exp_E: 5'b01100, exp_P: 1'b1, exp_valid: 1'b1};

    // Reset with the line toggling.
    rst_n = 1'b0;
    rx    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rx = ~rx;
    end
    chk("rst_E", 32'(E), 32'd0);
    chk("rst_P", 32'(P), 32'd1);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_erro", 32'(erro_quadro), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    rx    = 1'b1;
    rst_n = 1'b1;
    tick(20);
    chk("idle_E", 32'(E), 32'd0);
    chk("idle_P", 32'(P), 32'd1);
    chk("idle_ocupado", 32'(ocupado), 32'd0);
    chk("idle_pronto_cnt", 32'(pronto_cnt), 32'd0);
    chk("idle_erro_cnt", 32'(erro_cnt), 32'd0);

    // Table-driven single frames.
    for (int i = 0; i < 5; i++) begin
      rx = 1'b1;
      tick(6);
      p0 = pronto_cnt;
      e0 = erro_cnt;
      send_frame(vt[i].d, vt[i].p, vt[i].s, k);
      if (vt[i].s) begin
        rx = 1'b1;
        tick(3);
      end else begin
        tick(vt[i].low_extra);
        chk($sformatf("v%0d_espera_ocupado", i), 32'(ocupado), 32'd1);
        chk($sformatf("v%0d_espera_no_pronto", i), 32'(pronto_cnt - p0), 32'd0);
        rx = 1'b1;
        tick(6);
        chk($sformatf("v%0d_espera_exit", i), 32'(ocupado), 32'd0);
      end
      chk($sformatf("v%0d_pronto_pulses", i), 32'(pronto_cnt - p0), 32'(vt[i].exp_pronto));
      chk($sformatf("v%0d_erro_pulses", i), 32'(erro_cnt - e0), 32'(!vt[i].exp_pronto));
      if (vt[i].exp_pronto)
        chk($sformatf("v%0d_pronto_cycle", i), 32'(last_pronto_cyc), 32'(k + 32));
      else
        chk($sformatf("v%0d_erro_cycle", i), 32'(last_erro_cyc), 32'(k + 32));
      chk($sformatf("v%0d_E", i), 32'(E), 32'(vt[i].exp_E));
      chk($sformatf("v%0d_P", i), 32'(P), 32'(vt[i].exp_P));
      chk($sformatf("v%0d_validade", i), 32'(^{E, P}), 32'(vt[i].exp_valid));
    end

    // Glitch: one cycle low only.
    rx = 1'b1;
    tick(6);
    p0 = pronto_cnt;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    hi_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      tick(1);
      if (ocupado === 1'b1) hi_cnt++;
    end
    chk("glitch_ocupado_cycles", 32'(hi_cnt), 32'd2);
    chk("glitch_ocupado_low", 32'(ocupado), 32'd0);
    chk("glitch_no_pronto", 32'(pronto_cnt - p0), 32'd0);
    chk("glitch_E", 32'(E), 32'b01100);
    chk("glitch_P", 32'(P), 32'd1);

    // Back-to-back frames.
    tick(4);
    p0 = pronto_cnt;
    send_frame(5'b00010, 1'b0, 1'b1, k1);
    send_frame(5'b10101, 1'b0, 1'b1, k2);
    rx = 1'b1;
    tick(3);
    chk("b2b_pronto_pulses", 32'(pronto_cnt - p0), 32'd2);
    chk("b2b_first_cycle", 32'(pronto_cyc[p0]), 32'(k1 + 32));
    chk("b2b_spacing", 32'(pronto_cyc[p0 + 1] - pronto_cyc[p0]), 32'd32);
    chk("b2b_first_E", 32'(pronto_E[p0]), 32'b00010);
    chk("b2b_second_E", 32'(pronto_E[p0 + 1]), 32'b10101);
    chk("b2b_final_P", 32'(P), 32'd0);

    // Reset during D2 of a third frame.
    tick(6);
    p0 = pronto_cnt;
    e0 = erro_cnt;
    rx = 1'b0; tick(N);
    rx = 1'b1; tick(N);
    rx = 1'b1; tick(N);
    rx = 1'b0; tick(N / 2);
    chk("midrst_busy_before", 32'(ocupado), 32'd1);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_E", 32'(E), 32'd0);
    chk("midrst_P", 32'(P), 32'd1);
    chk("midrst_ocupado", 32'(ocupado), 32'd0);
    rx    = 1'b1;
    rst_n = 1'b1;
    tick(40);
    chk("midrst_no_pronto", 32'(pronto_cnt - p0), 32'd0);
    chk("midrst_no_erro", 32'(erro_cnt - e0), 32'd0);
    chk("midrst_hold_E", 32'(E), 32'd0);
    chk("midrst_hold_P", 32'(P), 32'd1);

    // Global pulse and hold properties.
    chk("pulse_overlap", 32'(overlap_err), 32'd0);
    chk("pulse_consecutive", 32'(consec_err), 32'd0);
    chk("ep_change_without_pronto", 32'(ep_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
